turn_countdown_display: RTL and testbench
=========================================

// Module: turn_countdown_display
// PURPOSE
//  Visible end of the turn-timer interface: consumes the timer's half-second tick and turn-handoff pulses.
//  Keeps per-turn remaining time as BCD M:SS and flags expiry.
//  Drives the board's 4-digit multiplexed 7-seg as "M.SS P": minutes, seconds, active player 1/2.
//  Sits between the 2-minute turn timer/button logic and the top-level seg/an/dp pins.
// PARAMETERS
//  TURN_SECONDS   120     per-turn budget in seconds; legal 1..599
//  TICKS_PER_SEC  2       tick_half pulses per decremented second
//  SCAN_DIV       99_999  clocks per digit slot minus 1 (1 kHz digit rate @100 MHz)
// PORTS
//  clock        in   1  system clock, 100 MHz
//  reset        in   1  synchronous, active-high
//  tick_half    in   1  1-cycle pulse per half second from turn timer
//  turn_switch  in   1  1-cycle pulse: turn handed to other player
//  start        in   1  1-cycle pulse: begin/restart game
//  player       out  1  0 = player 1, 1 = player 2
//  expired      out  1  high while in EXPIRED
//  seg          out  7  {g,f,e,d,c,b,a}, active low
//  an           out  4  digit enables, active low; an[3] = leftmost
//  dp           out  1  decimal point, active low
// BEHAVIOUR
//  Reset: state IDLE, time = TURN_SECONDS as BCD (min, s_tens, s_ones), half_cnt 0, player 0, expired 0,
//   scan_cnt 0, digit 0, an 4'b1111, seg 7'b1111111, dp 1; all outputs registered.
//  FSM IDLE -> RUN on start (time reloaded, half_cnt cleared); turn_switch in IDLE toggles player only.
//  RUN: each tick_half increments half_cnt; when half_cnt would hit TICKS_PER_SEC it clears and time decrements.
//   BCD decrement with borrow: s_ones 0->9 borrows s_tens; s_tens 0->5 borrows min. No divider.
//  RUN -> EXPIRED on the edge where time goes 0:01 -> 0:00; expired high that same edge; time holds 0:00.
//  turn_switch in RUN: toggle player, reload time, clear half_cnt, same edge.
//  turn_switch + final tick same cycle: switch wins, no expiry.
//  start in RUN: ignored.
//  EXPIRED: tick_half and turn_switch ignored.
//   start -> IDLE: time reloaded, player 0, expired 0.
//  Reset mid-operation: reset values on next edge regardless of state or pending pulses.
//  Scan: scan_cnt counts 0..SCAN_DIV.
//   At SCAN_DIV it wraps and digit advances 0->1->2->3->0.
//   an = ~(1<<digit), registered one cycle after digit changes.
//  Digit map:
//   digit0 = player+1.
//   digit1 = s_ones.
//   digit2 = s_tens.
//   digit3 = min; dp = 0 only when digit3 active.
//  Decoder: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000; other codes blank.
//  Display values track state in all states; IDLE shows the reloaded budget.
// CONFIGURATION
//  BLINK_LAST_10S_EN defined:
//   blink flag toggles on every tick_half while in RUN with time <= 0:10.
//   an forced 4'b1111 while flag = 1.
//   Flag cleared on reset, reload, and entry to EXPIRED; EXPIRED display steady 0.00.
//  BLINK_LAST_10S_EN undefined: no blink flag; display never blanked after reset.
// TESTING (TURN_SECONDS=5, TICKS_PER_SEC=2, SCAN_DIV=3)
//  Reset 2 cycles -> an=1111, seg=1111111, dp=1, expired=0, player=0; then scan shows 0.05 / 1.
//  start, 10 tick_half spaced 5 cycles -> time 5->0 on every 2nd tick; expired=1 on 10th tick's edge.
//   Further ticks leave 0:00.
//  start, 3 ticks, turn_switch -> player=1, time 0:05.
//   Next decrement needs exactly 2 more ticks (half_cnt cleared).
//  9 ticks then tick_half+turn_switch same cycle -> expired stays 0, time 0:05, player toggled.
//  reset asserted mid-RUN at 0:02 -> next edge IDLE, 0:05, player 0.
//   start in EXPIRED -> IDLE, expired 0.
//  Scan -> an cycles 1110,1101,1011,0111, each held 4 cycles.
//   Digit0 seg=1111001 (player 1); dp=0 only with an=0111.

Source files
------------

// File: rtl/turn_countdown_display.sv
// +----------------------------------------------------------------------------+
// | turn_countdown_display: per-turn BCD M:SS countdown with expiry flag,      |
// | driving a 4-digit multiplexed 7-seg as "M.SS P". Option: BLINK_LAST_10S_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module turn_countdown_display #(
  parameter int TURN_SECONDS  = 120,
  parameter int TICKS_PER_SEC = 2,
  parameter int SCAN_DIV      = 99_999
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_half,
  input  logic       turn_switch,
  input  logic       start,
  output logic       player,
  output logic       expired,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam logic [3:0] RELOAD_MINS = 4'(TURN_SECONDS / 60);
  localparam logic [3:0] RELOAD_TENS = 4'((TURN_SECONDS % 60) / 10);
  localparam logic [3:0] RELOAD_ONES = 4'(TURN_SECONDS % 10);
  localparam int HALF_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(TICKS_PER_SEC - 1);
  localparam int SCAN_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [3:0]        mins, secs_tens, secs_ones;
  logic [3:0]        next_mins, next_tens, next_ones;
  logic [HALF_W-1:0] half_cnt, next_half;
  logic              next_player;
  logic              reload;
  logic              blank;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mins      <= RELOAD_MINS;
      secs_tens <= RELOAD_TENS;
      secs_ones <= RELOAD_ONES;
      half_cnt  <= '0;
      player    <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= next_state;
      mins      <= next_mins;
      secs_tens <= next_tens;
      secs_ones <= next_ones;
      half_cnt  <= next_half;
      player    <= next_player;
      expired   <= (next_state == EXPIRED);
    end
  end

  always_comb begin
    next_state  = state;
    next_mins   = mins;
    next_tens   = secs_tens;
    next_ones   = secs_ones;
    next_half   = half_cnt;
    next_player = player;
    reload      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          reload     = 1'b1;
        end
        if (turn_switch) next_player = ~player;
      end
      RUN: begin
        // A handoff always beats a coincident tick, so the final tick cannot expire.
        if (turn_switch) begin
          next_player = ~player;
          reload      = 1'b1;
        end else if (tick_half) begin
          if (half_cnt == HALF_LAST) begin
            next_half = '0;
            if (secs_ones != 4'd0) begin
              next_ones = secs_ones - 4'd1;
            end else begin
              next_ones = 4'd9;
              if (secs_tens != 4'd0) begin
                next_tens = secs_tens - 4'd1;
              end else begin
                next_tens = 4'd5;
                next_mins = mins - 4'd1;
              end
            end
            if (mins == 4'd0 && secs_tens == 4'd0 && secs_ones == 4'd1)
              next_state = EXPIRED;
          end else begin
            next_half = half_cnt + 1'b1;
          end
        end
      end
      EXPIRED: begin
        if (start) begin
          next_state  = IDLE;
          next_player = 1'b0;
          reload      = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (reload) begin
      next_mins = RELOAD_MINS;
      next_tens = RELOAD_TENS;
      next_ones = RELOAD_ONES;
      next_half = '0;
    end
  end

`ifdef BLINK_LAST_10S_EN
  logic blink;
  logic last_ten;

  assign last_ten = (mins == 4'd0) &&
                    ((secs_tens == 4'd0) || (secs_tens == 4'd1 && secs_ones == 4'd0));

  always_ff @(posedge clock) begin
    if (reset || reload || next_state == EXPIRED)
      blink <= 1'b0;
    else if (state == RUN && tick_half && last_ten)
      blink <= ~blink;
  end

  assign blank = blink;
`else
  assign blank = 1'b0;
`endif

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit;
  logic [3:0]        digit_val;
  logic [6:0]        seg_dec;

  always_comb begin
    case (digit)
      2'd0:    digit_val = {3'b000, player} + 4'd1;
      2'd1:    digit_val = secs_ones;
      2'd2:    digit_val = secs_tens;
      default: digit_val = mins;
    endcase
  end

  always_comb begin
    seg_dec = 7'b1111111;
    case (digit_val)
      4'd0: seg_dec = 7'b1000000;
      4'd1: seg_dec = 7'b1111001;
      4'd2: seg_dec = 7'b0100100;
      4'd3: seg_dec = 7'b0110000;
      4'd4: seg_dec = 7'b0011001;
      4'd5: seg_dec = 7'b0010010;
      4'd6: seg_dec = 7'b0000010;
      4'd7: seg_dec = 7'b1111000;
      4'd8: seg_dec = 7'b0000000;
      4'd9: seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
      an       <= 4'b1111;
      seg      <= 7'b1111111;
      dp       <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        digit    <= digit + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= blank ? 4'b1111 : ~(4'b0001 << digit);
      seg <= seg_dec;
      dp  <= (digit != 2'd3);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_turn_countdown_display.sv
// +----------------------------------------------------------------------------+
// | tb_turn_countdown_display: scoreboard bench for turn_countdown_display.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_turn_countdown_display;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_half = 1'b0;
  logic       turn_switch = 1'b0;
  logic       start = 1'b0;
  logic       player, expired, dp;
  logic [6:0] seg;
  logic [3:0] an;

  turn_countdown_display #(
    .TURN_SECONDS (5),
    .TICKS_PER_SEC(2),
    .SCAN_DIV     (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick_half  (tick_half),
    .turn_switch(turn_switch),
    .start      (start),
    .player     (player),
    .expired    (expired),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // kind 0: {player,expired}; 1: captured display frame; 2: an; 3: raw outputs
  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  chk_t        cur;
  int          compared = 0;
  int          mismatched = 0;
  logic [6:0]  fseg [4];
  logic [3:0]  fdp;
  logic [31:0] act;
  logic        drain_fail = 1'b0;

  function automatic logic [6:0] seg7(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [31:0] frame(input bit p, input int m, input int t, input int o);
    return {4'b0111, seg7(m), seg7(t), seg7(o), seg7(p ? 2 : 1)};
  endfunction

  // Monitor: latch each digit as it is scanned, then retire every due expectation.
  always @(negedge clock) begin
    case (an)
      4'b1110: begin fseg[0] = seg; fdp[0] = dp; end
      4'b1101: begin fseg[1] = seg; fdp[1] = dp; end
      4'b1011: begin fseg[2] = seg; fdp[2] = dp; end
      4'b0111: begin fseg[3] = seg; fdp[3] = dp; end
      default: ;
    endcase
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      cur = sb.pop_front();
      case (cur.kind)
        0:       act = {30'd0, player, expired};
        1:       act = {fdp[3], fdp[2], fdp[1], fdp[0], fseg[3], fseg[2], fseg[1], fseg[0]};
        2:       act = {28'd0, an};
        default: act = {18'd0, an, seg, dp, expired, player};
      endcase
      compared++;
      if (act !== cur.exp) begin
        mismatched++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", cur.name, act, cur.exp, cycle);
      end
    end
    if (drain_fail && sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations never retired", sb.size());
      sb.delete();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input string name, input int kind, input logic [31:0] exp, input int due);
    sb.push_back('{due, kind, exp, name});
  endtask

  task automatic chk_status(input string name, input bit p, input bit e);
    push(name, 0, {30'd0, p, e}, cycle);
  endtask

  task automatic chk_frame(input string name, input bit p, input int m, input int t, input int o);
    cyc(20);
    push(name, 1, frame(p, m, t, o), cycle);
  endtask

  task automatic pulse(input logic t, input logic s, input logic st);
    tick_half   = t;
    turn_switch = s;
    start       = st;
    cyc(1);
    tick_half   = 1'b0;
    turn_switch = 1'b0;
    start       = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      pulse(1'b1, 1'b0, 1'b0);
      cyc(4);
    end
  endtask

  initial begin
    logic [3:0] onehot;
    int         guard;
    reset = 1'b1;
    cyc(2);
    push("reset_outputs", 3, {18'd0, 4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}, cycle);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      onehot = 4'b0001 << (k / 4);
      push($sformatf("scan_an_%0d", k), 2, {28'd0, ~onehot}, cycle + 1 + k);
    end
    chk_frame("idle_budget", 1'b0, 0, 0, 5);

    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      if (i == 9)  chk_status("pre_expiry", 1'b0, 1'b0);
      if (i == 10) chk_status("expiry_edge", 1'b0, 1'b1);
      cyc(4);
      if (i % 2 == 0) chk_frame($sformatf("run_tick%0d", i), 1'b0, 0, 0, 5 - i / 2);
    end
    tick_n(2);
    chk_frame("hold_zero", 1'b0, 0, 0, 0);
    chk_status("still_expired", 1'b0, 1'b1);

    pulse(1'b0, 1'b0, 1'b1);
    chk_status("expired_start_idle", 1'b0, 1'b0);
    chk_frame("idle_reload", 1'b0, 0, 0, 5);

    pulse(1'b0, 1'b0, 1'b1);
    tick_n(3);
    pulse(1'b0, 1'b1, 1'b0);
    chk_status("switch_player", 1'b1, 1'b0);
    chk_frame("switch_reload", 1'b1, 0, 0, 5);
    tick_n(1);
    chk_frame("half_cleared", 1'b1, 0, 0, 5);
    tick_n(1);
    chk_frame("dec_after_two", 1'b1, 0, 0, 4);

    pulse(1'b0, 1'b1, 1'b0);
    tick_n(9);
    pulse(1'b1, 1'b1, 1'b0);
    chk_status("switch_beats_expiry", 1'b1, 1'b0);
    chk_frame("switch_beats_time", 1'b1, 0, 0, 5);

    tick_n(6);
    chk_frame("at_0_02", 1'b1, 0, 0, 2);
    reset     = 1'b1;
    tick_half = 1'b1;
    cyc(1);
    reset     = 1'b0;
    tick_half = 1'b0;
    chk_status("midrun_reset", 1'b0, 1'b0);
    chk_frame("reset_reload", 1'b0, 0, 0, 5);
    tick_n(2);
    chk_frame("idle_ignores_tick", 1'b0, 0, 0, 5);

    pulse(1'b0, 1'b1, 1'b0);
    chk_status("idle_toggle", 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    tick_n(1);
    pulse(1'b0, 1'b0, 1'b1);
    tick_n(1);
    chk_frame("start_ignored_run", 1'b1, 0, 0, 4);

    tick_n(8);
    chk_status("second_expiry", 1'b1, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    chk_status("expired_ignores_switch", 1'b1, 1'b1);
    chk_frame("expired_frame", 1'b1, 0, 0, 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk_status("expired_start_player0", 1'b0, 1'b0);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      cyc(1);
      guard++;
    end
    if (sb.size() > 0) drain_fail = 1'b1;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
